// File: rtl/dual_update_horizon_if.sv
// ---------------------------------------------------------------------------
// dual_update_horizon_if
// Bundles the knot-input stream, the updated-knot output stream and the
// per-pass status signals of dual_update_horizon.
//   slave  : view taken by the dual-update block
//   master : view taken by the upstream/downstream driver
// Signals:
//   start, in_valid/in_ready, u_k z_k y_k x_k v_k g_k    knot input beat
//   out_valid/out_ready, y_out g_out out_knot out_last    updated knot
//   res_u res_x done                                      pass status
//   sat_flag (only when DUAL_UPDATE_SAT_EN is defined)    sticky clamp flag
// ---------------------------------------------------------------------------
interface dual_update_horizon_if #(
    parameter int STATE_DIM   = 12,
    parameter int CONTROL_DIM = 4,
    parameter int W           = 16,
    parameter int HORIZON     = 10
);
    localparam int KW = $clog2(HORIZON) + 1;

    logic                            start;
    logic                            in_valid;
    logic                            in_ready;
    logic [CONTROL_DIM-1:0][W-1:0]   u_k;
    logic [CONTROL_DIM-1:0][W-1:0]   z_k;
    logic [CONTROL_DIM-1:0][W-1:0]   y_k;
    logic [STATE_DIM-1:0][W-1:0]     x_k;
    logic [STATE_DIM-1:0][W-1:0]     v_k;
    logic [STATE_DIM-1:0][W-1:0]     g_k;
    logic                            out_valid;
    logic                            out_ready;
    logic [CONTROL_DIM-1:0][W-1:0]   y_out;
    logic [STATE_DIM-1:0][W-1:0]     g_out;
    logic [KW-1:0]                   out_knot;
    logic                            out_last;
    logic [W:0]                      res_u;
    logic [W:0]                      res_x;
    logic                            done;
`ifdef DUAL_UPDATE_SAT_EN
    logic                            sat_flag;

    modport slave (
        input  start, in_valid, u_k, z_k, y_k, x_k, v_k, g_k, out_ready,
        output in_ready, out_valid, y_out, g_out, out_knot, out_last,
               res_u, res_x, done, sat_flag
    );
    modport master (
        output start, in_valid, u_k, z_k, y_k, x_k, v_k, g_k, out_ready,
        input  in_ready, out_valid, y_out, g_out, out_knot, out_last,
               res_u, res_x, done, sat_flag
    );
`else
    modport slave (
        input  start, in_valid, u_k, z_k, y_k, x_k, v_k, g_k, out_ready,
        output in_ready, out_valid, y_out, g_out, out_knot, out_last,
               res_u, res_x, done
    );
    modport master (
        output start, in_valid, u_k, z_k, y_k, x_k, v_k, g_k, out_ready,
        input  in_ready, out_valid, y_out, g_out, out_knot, out_last,
               res_u, res_x, done
    );
`endif
endinterface

// File: rtl/dual_update_horizon.sv
// ---------------------------------------------------------------------------
// dual_update_horizon
// Streaming ADMM dual update over one MPC horizon, one knot per beat:
//   y_out = y + ((u - z) >>> ALPHA_SHIFT)
//   g_out = g + ((x - v) >>> ALPHA_SHIFT)
// and the running primal residuals max|u-z| / max|x-v| over the pass.
// Ports:
//   clk, reset (asynchronous, active-high)
//   bus : dual_update_horizon_if.slave (knot in, updated knot out, status)
// Optional feature macro DUAL_UPDATE_SAT_EN: when defined the update is
// clamped to the W-bit signed range and bus.sat_flag records any clamp in
// the pass; when undefined the update wraps to W bits.
// ---------------------------------------------------------------------------
module dual_update_horizon #(
    parameter int STATE_DIM   = 12,
    parameter int CONTROL_DIM = 4,
    parameter int W           = 16,
    parameter int HORIZON     = 10,
    parameter int ALPHA_SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    dual_update_horizon_if.slave    bus
);
    localparam int KW = $clog2(HORIZON) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t                        state_reg, state_next;
    logic [KW-1:0]                 knot_reg;
    logic [KW-1:0]                 out_knot_reg;
    logic                          out_valid_reg;
    logic                          out_last_reg;
    logic                          done_reg, done_next;
    logic [CONTROL_DIM-1:0][W-1:0] y_out_reg, y_next;
    logic [STATE_DIM-1:0][W-1:0]   g_out_reg, g_next;
    logic [W:0]                    res_u_reg, res_u_next;
    logic [W:0]                    res_x_reg, res_x_next;
    logic [W:0]                    abs_u [CONTROL_DIM];
    logic [W:0]                    abs_x [STATE_DIM];
    logic                          in_ready_int;
    logic                          accept;
    logic                          take;
    logic                          last_knot;
`ifdef DUAL_UPDATE_SAT_EN
    logic [CONTROL_DIM-1:0]        clamp_u;
    logic [STATE_DIM-1:0]          clamp_x;
    logic                          sat_reg;
`endif

    // Difference at W+1 bits can never overflow.
    function automatic logic signed [W:0] lane_diff(input logic [W-1:0] a,
                                                     input logic [W-1:0] b);
        return $signed({a[W-1], a}) - $signed({b[W-1], b});
    endfunction

    function automatic logic [W:0] lane_abs(input logic signed [W:0] d);
        return d[W] ? $unsigned(-d) : $unsigned(d);
    endfunction

`ifdef DUAL_UPDATE_SAT_EN
    // Returns {clamped, value}. The W+2 bit sum fits in W bits exactly
    // when its top three bits agree.
    function automatic logic [W:0] lane_update(input logic [W-1:0] dual,
                                               input logic signed [W:0] d);
        logic signed [W+1:0] t;
        t = $signed({{2{dual[W-1]}}, dual}) + (W+2)'(d >>> ALPHA_SHIFT);
        if (t[W+1:W-1] == 3'b000 || t[W+1:W-1] == 3'b111)
            return {1'b0, t[W-1:0]};
        return t[W+1] ? {1'b1, 1'b1, {(W-1){1'b0}}} : {1'b1, 1'b0, {(W-1){1'b1}}};
    endfunction
`else
    // Two's-complement wrap: only the low W bits of the sum are kept.
    function automatic logic [W-1:0] lane_update(input logic [W-1:0] dual,
                                                 input logic signed [W:0] d);
        return dual + W'(d >>> ALPHA_SHIFT);
    endfunction
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CONTROL_DIM; gi++) begin : g_ctrl
            logic signed [W:0] d;
            assign d         = lane_diff(bus.u_k[gi], bus.z_k[gi]);
            assign abs_u[gi] = lane_abs(d);
`ifdef DUAL_UPDATE_SAT_EN
            assign {clamp_u[gi], y_next[gi]} = lane_update(bus.y_k[gi], d);
`else
            assign y_next[gi] = lane_update(bus.y_k[gi], d);
`endif
        end
        for (gi = 0; gi < STATE_DIM; gi++) begin : g_state
            logic signed [W:0] d;
            assign d         = lane_diff(bus.x_k[gi], bus.v_k[gi]);
            assign abs_x[gi] = lane_abs(d);
`ifdef DUAL_UPDATE_SAT_EN
            assign {clamp_x[gi], g_next[gi]} = lane_update(bus.g_k[gi], d);
`else
            assign g_next[gi] = lane_update(bus.g_k[gi], d);
`endif
        end
    endgenerate

    // Running residual: max over this beat's lanes and the value so far.
    always_comb begin
        res_u_next = res_u_reg;
        res_x_next = res_x_reg;
        for (int i = 0; i < CONTROL_DIM; i++)
            if (abs_u[i] > res_u_next) res_u_next = abs_u[i];
        for (int i = 0; i < STATE_DIM; i++)
            if (abs_x[i] > res_x_next) res_x_next = abs_x[i];
    end

    always_comb begin
        state_next   = state_reg;
        in_ready_int = 1'b0;
        done_next    = 1'b0;
        take         = out_valid_reg && bus.out_ready;
        last_knot    = (knot_reg == KW'(HORIZON - 1));
        case (state_reg)
            IDLE: if (bus.start) state_next = RUN;
            RUN: begin
                // One-entry output register: refill in the cycle it drains.
                in_ready_int = !out_valid_reg || bus.out_ready;
                if (in_ready_int && bus.in_valid && last_knot) state_next = DRAIN;
            end
            DRAIN: begin
                if (take) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        accept = in_ready_int && bus.in_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            knot_reg      <= '0;
            out_knot_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            done_reg      <= 1'b0;
            y_out_reg     <= '0;
            g_out_reg     <= '0;
            res_u_reg     <= '0;
            res_x_reg     <= '0;
`ifdef DUAL_UPDATE_SAT_EN
            sat_reg       <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            if (state_reg == IDLE && bus.start) begin
                knot_reg  <= '0;
                res_u_reg <= '0;
                res_x_reg <= '0;
`ifdef DUAL_UPDATE_SAT_EN
                sat_reg   <= 1'b0;
`endif
            end
            if (accept) begin
                y_out_reg     <= y_next;
                g_out_reg     <= g_next;
                out_knot_reg  <= knot_reg;
                out_last_reg  <= last_knot;
                out_valid_reg <= 1'b1;
                knot_reg      <= knot_reg + KW'(1);
                res_u_reg     <= res_u_next;
                res_x_reg     <= res_x_next;
`ifdef DUAL_UPDATE_SAT_EN
                sat_reg       <= sat_reg | (|clamp_u) | (|clamp_x);
`endif
            end else if (take) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_reg;
    assign bus.y_out     = y_out_reg;
    assign bus.g_out     = g_out_reg;
    assign bus.out_knot  = out_knot_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.res_u     = res_u_reg;
    assign bus.res_x     = res_x_reg;
    assign bus.done      = done_reg;
`ifdef DUAL_UPDATE_SAT_EN
    assign bus.sat_flag  = sat_reg;
`endif
endmodule

// File: tb/tb_dual_update_horizon.sv
// ---------------------------------------------------------------------------
// tb_dual_update_horizon
// Two instances driven in lockstep from the same stimulus: dut_a with
// ALPHA_SHIFT=0 and dut_b with ALPHA_SHIFT=2 (HORIZON=3, W=16). Expected
// values come from an integer reference model (floor division for the shift,
// modulo wrap or clamp for the W-bit reduction, max of |a-b| for residuals).
// ---------------------------------------------------------------------------
module tb_dual_update_horizon;
    localparam int CD = 4;
    localparam int SD = 12;
    localparam int W  = 16;
    localparam int H  = 3;

    typedef logic [CD-1:0][W-1:0] cvec_t;
    typedef logic [SD-1:0][W-1:0] svec_t;

    logic  clk = 1'b0;
    logic  reset;
    logic  start, in_valid, out_ready;
    cvec_t u, z, y;
    svec_t x, v, g;
    int    checks = 0;
    int    errors = 0;

    cvec_t ku [H];
    cvec_t kz [H];
    cvec_t ky [H];
    svec_t kx [H];
    svec_t kv [H];
    svec_t kg [H];

    always #5 clk = ~clk;

    dual_update_horizon_if #(.STATE_DIM(SD), .CONTROL_DIM(CD), .W(W), .HORIZON(H)) ifa ();
    dual_update_horizon_if #(.STATE_DIM(SD), .CONTROL_DIM(CD), .W(W), .HORIZON(H)) ifb ();

    assign ifa.start = start;     assign ifb.start = start;
    assign ifa.in_valid = in_valid; assign ifb.in_valid = in_valid;
    assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;
    assign ifa.u_k = u; assign ifa.z_k = z; assign ifa.y_k = y;
    assign ifa.x_k = x; assign ifa.v_k = v; assign ifa.g_k = g;
    assign ifb.u_k = u; assign ifb.z_k = z; assign ifb.y_k = y;
    assign ifb.x_k = x; assign ifb.v_k = v; assign ifb.g_k = g;

    dual_update_horizon #(.STATE_DIM(SD), .CONTROL_DIM(CD), .W(W), .HORIZON(H), .ALPHA_SHIFT(0))
        dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    dual_update_horizon #(.STATE_DIM(SD), .CONTROL_DIM(CD), .W(W), .HORIZON(H), .ALPHA_SHIFT(2))
        dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int sx(input logic [W-1:0] a);
        return int'($signed(a));
    endfunction

    // floor(d / 2^sh)
    function automatic int fshift(input int d, input int sh);
        int p, q;
        p = 1 << sh;
        q = d / p;
        if (d < 0 && q * p != d) q = q - 1;
        return q;
    endfunction

    function automatic int fit(input int t);
`ifdef DUAL_UPDATE_SAT_EN
        if (t > 32767) return 32767;
        if (t < -32768) return -32768;
        return t;
`else
        int r;
        r = t % 65536;
        if (r < 0) r = r + 65536;
        if (r > 32767) r = r - 65536;
        return r;
`endif
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic cvec_t exp_y(input int k, input int sh);
        cvec_t e;
        for (int i = 0; i < CD; i++)
            e[i] = W'(fit(sx(ky[k][i]) + fshift(sx(ku[k][i]) - sx(kz[k][i]), sh)));
        return e;
    endfunction

    function automatic svec_t exp_g(input int k, input int sh);
        svec_t e;
        for (int i = 0; i < SD; i++)
            e[i] = W'(fit(sx(kg[k][i]) + fshift(sx(kx[k][i]) - sx(kv[k][i]), sh)));
        return e;
    endfunction

`ifdef DUAL_UPDATE_SAT_EN
    function automatic bit knot_clips(input int k, input int sh);
        bit c;
        int t;
        c = 1'b0;
        for (int i = 0; i < CD; i++) begin
            t = sx(ky[k][i]) + fshift(sx(ku[k][i]) - sx(kz[k][i]), sh);
            if (t > 32767 || t < -32768) c = 1'b1;
        end
        for (int i = 0; i < SD; i++) begin
            t = sx(kg[k][i]) + fshift(sx(kx[k][i]) - sx(kv[k][i]), sh);
            if (t > 32767 || t < -32768) c = 1'b1;
        end
        return c;
    endfunction
`endif

    // ---------------- stimulus helpers ----------------
    task automatic fill_const(input int cu, input int cz, input int cy,
                              input int cx, input int cv, input int cg);
        for (int k = 0; k < H; k++) begin
            for (int i = 0; i < CD; i++) begin
                ku[k][i] = W'(cu); kz[k][i] = W'(cz); ky[k][i] = W'(cy);
            end
            for (int i = 0; i < SD; i++) begin
                kx[k][i] = W'(cx); kv[k][i] = W'(cv); kg[k][i] = W'(cg);
            end
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < H; k++) begin
            for (int i = 0; i < CD; i++) begin
                ku[k][i] = W'($urandom); kz[k][i] = W'($urandom); ky[k][i] = W'($urandom);
            end
            for (int i = 0; i < SD; i++) begin
                kx[k][i] = W'($urandom); kv[k][i] = W'($urandom); kg[k][i] = W'($urandom);
            end
        end
    endtask

    task automatic load_knot(input int k);
        u = ku[k]; z = kz[k]; y = ky[k];
        x = kx[k]; v = kv[k]; g = kg[k];
    endtask

    // mode 0: full throughput, 1: out_ready low 4 cycles after first beat,
    // 2: random gaps/backpressure, 3: start held high during RUN.
    // abort_after > 0: assert reset once that many knots were accepted.
    task automatic run_pass(input string name, input int mode, input int abort_after);
        int    idx, oidx, stall_left, mu, mx;
        bit    exp_done, got_done, stalled, aborted;
        cvec_t snap;
`ifdef DUAL_UPDATE_SAT_EN
        bit    sa, sb;
        sa = 1'b0; sb = 1'b0;
`endif
        idx = 0; oidx = 0; stall_left = 4; mu = 0; mx = 0;
        exp_done = 1'b0; got_done = 1'b0; stalled = 1'b0; aborted = 1'b0;
        snap = '0;

        chk({name, ":idle_in_ready"}, {ifa.in_ready, ifb.in_ready}, 2'b00);
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        start = (mode == 3);

        for (int cyc = 0; cyc < 200; cyc++) begin
            if (abort_after > 0 && idx == abort_after) begin
                in_valid = 1'b0; start = 1'b0; reset = 1'b1;
                #1;
                chk({name, ":rst_y_out"}, {ifa.y_out, ifb.y_out}, '0);
                chk({name, ":rst_g_out"}, {ifa.g_out, ifb.g_out}, '0);
                chk({name, ":rst_flags"},
                    {ifa.out_valid, ifa.out_last, ifa.done, ifa.in_ready,
                     ifb.out_valid, ifb.out_last, ifb.done, ifb.in_ready}, '0);
                chk({name, ":rst_knot_res"},
                    {ifa.out_knot, ifa.res_u, ifa.res_x, ifb.res_u, ifb.res_x}, '0);
                @(posedge clk); @(negedge clk);
                chk({name, ":rst_no_done"}, {ifa.done, ifb.done, ifa.in_ready}, 3'b000);
                reset = 1'b0;
                aborted = 1'b1;
                break;
            end

            in_valid = (idx < H) && (mode != 2 || $urandom_range(0, 3) != 0);
            if (idx < H) load_knot(idx);
            if (mode == 3) start = (idx < H);
            case (mode)
                1:       out_ready = (stall_left == 0);
                2:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b1;
            endcase
            #1;

            if (stalled) chk({name, ":hold_y_out"}, ifa.y_out, snap);
            stalled = 1'b0;
            chk({name, ":done"}, {ifa.done, ifb.done}, {exp_done, exp_done});
            exp_done = 1'b0;
            if (ifa.done) begin
                got_done = 1'b1;
                break;
            end

            if (ifa.out_valid && !out_ready) begin
                chk({name, ":stall_in_ready"}, {ifa.in_ready, ifb.in_ready}, 2'b00);
                snap = ifa.y_out;
                stalled = 1'b1;
                if (mode == 1 && stall_left > 0) stall_left--;
            end
            if (mode == 0 && idx < H) chk({name, ":full_rate"}, ifa.in_ready, 1'b1);

            if (ifa.out_valid && out_ready) begin
                chk({name, ":y_a"}, ifa.y_out, exp_y(oidx, 0));
                chk({name, ":g_a"}, ifa.g_out, exp_g(oidx, 0));
                chk({name, ":y_b"}, ifb.y_out, exp_y(oidx, 2));
                chk({name, ":g_b"}, ifb.g_out, exp_g(oidx, 2));
                chk({name, ":knot"}, ifa.out_knot, oidx);
                chk({name, ":last"}, {ifa.out_last, ifb.out_last, ifb.out_valid},
                    {(oidx == H - 1), (oidx == H - 1), 1'b1});
                if (oidx == H - 1) exp_done = 1'b1;
                oidx++;
            end

            if (in_valid && ifa.in_ready) begin
                for (int i = 0; i < CD; i++)
                    if (iabs(sx(ku[idx][i]) - sx(kz[idx][i])) > mu)
                        mu = iabs(sx(ku[idx][i]) - sx(kz[idx][i]));
                for (int i = 0; i < SD; i++)
                    if (iabs(sx(kx[idx][i]) - sx(kv[idx][i])) > mx)
                        mx = iabs(sx(kx[idx][i]) - sx(kv[idx][i]));
`ifdef DUAL_UPDATE_SAT_EN
                sa = sa | knot_clips(idx, 0);
                sb = sb | knot_clips(idx, 2);
`endif
                idx++;
            end
            @(posedge clk); @(negedge clk);
        end

        if (!aborted) begin
            chk({name, ":done_seen"}, got_done, 1'b1);
            chk({name, ":beats_out"}, oidx, H);
            chk({name, ":res_u"}, {ifa.res_u, ifb.res_u}, {17'(mu), 17'(mu)});
            chk({name, ":res_x"}, {ifa.res_x, ifb.res_x}, {17'(mx), 17'(mx)});
`ifdef DUAL_UPDATE_SAT_EN
            chk({name, ":sat_flag"}, {ifa.sat_flag, ifb.sat_flag}, {sa, sb});
`endif
            // Back in IDLE: single done pulse, residuals hold, no acceptance.
            start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); @(negedge clk); #1;
            chk({name, ":idle_after"}, {ifa.done, ifa.in_ready, ifa.out_valid}, 3'b000);
            chk({name, ":res_hold"}, {ifa.res_u, ifa.res_x}, {17'(mu), 17'(mx)});
            in_valid = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        u = '0; z = '0; y = '0; x = '0; v = '0; g = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset:flags", {ifa.in_ready, ifa.out_valid, ifa.out_last, ifa.done,
                            ifb.in_ready, ifb.out_valid, ifb.out_last, ifb.done}, '0);
        chk("reset:data", {ifa.y_out, ifa.g_out}, '0);
        chk("reset:knot_res", {ifa.out_knot, ifa.res_u, ifa.res_x}, '0);
        reset = 1'b0;
        @(negedge clk);

        fill_const(5, 2, 10, -4, 1, 0);
        run_pass("basic", 0, 0);

        fill_rand();
        run_pass("backpressure", 1, 0);

        fill_const(-7, 0, 0, 3, 3, -1);
        run_pass("shift", 0, 0);

        fill_const(32767, -32768, 32767, -32768, 32767, -32768);
        run_pass("overflow", 0, 0);

        fill_rand();
        run_pass("start_in_run", 3, 0);

        fill_rand();
        run_pass("abort", 0, 2);

        fill_rand();
        run_pass("after_abort", 0, 0);

        for (int p = 0; p < 6; p++) begin
            fill_rand();
            run_pass("random", 2, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dual_update_horizon.md
Name: dual_update_horizon

Overview:
- Streaming ADMM dual-variable update over a full MPC horizon. Processes one knot per accepted beat:
  - y_out = y + ((u - z) >>> ALPHA_SHIFT)
  - g_out = g + ((x - v) >>> ALPHA_SHIFT)
- Tracks the primal residuals (max |u-z| and max |x-v|) across all HORIZON knots for the convergence check.
- Sits between the projection/slack stage (upstream) and the dual memory and convergence logic (downstream).

Parameters:
- STATE_DIM, 12, state lanes per knot
- CONTROL_DIM, 4, control lanes per knot
- W, 16, signed fixed-point data width
- HORIZON, 10, knots per solve iteration (>=1)
- ALPHA_SHIFT, 0, step-size scaling; the difference is arithmetic right-shifted by this amount (0..W-1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a horizon pass (sampled only in IDLE)
- in_valid  in  1  knot inputs valid
- in_ready  out  1  block accepts knot this cycle
- u_k, z_k, y_k  in  [CONTROL_DIM] x W signed  control primal, slack, dual
- x_k, v_k, g_k  in  [STATE_DIM] x W signed  state primal, slack, dual
- out_valid  out  1  updated knot available
- out_ready  in  1  downstream accepts output
- y_out  out  [CONTROL_DIM] x W signed  updated control dual
- g_out  out  [STATE_DIM] x W signed  updated state dual
- out_knot  out  $clog2(HORIZON)+1  knot index of current output
- out_last  out  1  current output is knot HORIZON-1
- res_u  out  W+1 unsigned  max |u-z| over the pass
- res_x  out  W+1 unsigned  max |x-v| over the pass
- done  out  1  one-cycle pulse when the pass is complete

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high. Reset mid-operation aborts the pass immediately with no done pulse.
- Reset values: state=IDLE; in_ready, out_valid, out_last, done = 0; y_out, g_out, out_knot, res_u, res_x = 0; internal knot counter = 0.
- State machine: IDLE -> RUN -> DRAIN -> IDLE.
  - IDLE: in_ready=0. start=1 -> clear res_u/res_x and the counter; go to RUN.
  - RUN: in_ready = !out_valid || out_ready (one-entry output register, full throughput). A beat is accepted when in_valid && in_ready.
  - Each accepted beat loads y_out/g_out, sets out_knot = counter, sets out_last = (counter == HORIZON-1), sets out_valid=1, and increments the counter. Latency is 1 cycle from acceptance to out_valid.
  - Accepting knot HORIZON-1 -> go to DRAIN; in_ready=0.
  - DRAIN: when out_valid && out_ready (the last output is taken), pulse done=1 for exactly one cycle and go to IDLE.
- Output hold: out_valid deasserts when out_ready=1 and no new beat is accepted in the same cycle. While out_valid && !out_ready, the outputs hold stable and in_ready=0.
- start outside IDLE is ignored.
- res_u and res_x hold their values from done until the next accepted start.
- Arithmetic, per lane:
  - d = a - b computed at W+1 bits, no overflow.
  - s = d >>> ALPHA_SHIFT (arithmetic shift).
  - t = dual + s computed at W+2 bits.
  - The result is reduced to W bits per the optional-feature rule.
- Residual: |d| at W+1 bits, unsigned. The residual register is updated with the max over all lanes of the beat and its previous value. Computed on the unshifted d.
- Degenerate case HORIZON=1: the first accepted beat goes directly to DRAIN.

Optional Feature:
- Macro: DUAL_UPDATE_SAT_EN.
- Defined:
  - t is clamped to [-2^(W-1), 2^(W-1)-1].
  - Adds output sat_flag (1 bit) that goes sticky-high on any clamp during the pass. It clears on accepted start and resets to 0.
- Undefined:
  - t is truncated to its low W bits (two's-complement wrap).
  - No sat_flag port.

Test Plan:
- Basic pass (W=16, HORIZON=3, ALPHA_SHIFT=0): u=5, z=2, y=10 all lanes; x=-4, v=1, g=0.
  - Every knot: y_out=13, g_out=-5.
  - out_knot = 0, 1, 2; out_last only on knot 2.
  - res_u=3, res_x=5; done pulses once, 1 cycle after the last output handshake.
- Backpressure: hold out_ready=0 for 4 cycles after the first beat.
  - in_ready=0 and y_out stable throughout.
  - No beats are lost or duplicated; full throughput (1 knot/cycle) with out_ready=1.
- Shift: ALPHA_SHIFT=2, u=-7, z=0, y=0.
  - y_out=-2 (arithmetic shift rounds toward -inf).
  - res_u=7.
- Overflow: u=32767, z=-32768, y=32767.
  - With DUAL_UPDATE_SAT_EN: y_out=32767 and sat_flag=1.
  - Without it: the wrapped low 16 bits of 98302 (y_out=-32770 mod 2^16, i.e. 0x7FFE).
- Reset and start misuse:
  - Assert reset after knot 1 of 3: all outputs return to 0 immediately, no done, state=IDLE.
  - start during RUN is ignored (the counter is not cleared).
